gray_to_binary_seq: RTL and testbench

Sequential Gray-to-binary decoder, the inverse of the team's binary_to_gray encoder. It accepts an N-bit Gray word over a valid/ready handshake and decodes it serially, MSB first, one bit per clock. It presents the binary result on a held valid/ready output. It is used on the receive side of Gray-coded counters and pointers, for example after a CDC synchroniser.

---
 rtl/gray_pkg.sv | 15 +
 rtl/gray_step_checker.sv | 44 ++++
 rtl/gray_to_binary_seq.sv | 105 ++++++++++
 tb/tb_gray_to_binary_seq.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gray_pkg.sv
// Shared types and helpers for the serial Gray decoder.
// Holds the FSM state enum and the index-width function.
package gray_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/gray_step_checker.sv
// Flags accepted Gray words that differ from the previous one in
// two or more bits. Built only with GRAY_STEP_CHECK_EN defined.
module gray_step_checker
  import gray_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         accept,
  input  logic [N-1:0] gray_in,
  output logic         err
);

  logic [N-1:0] prev_gray;
  logic [N-1:0] diff;
  logic [31:0]  ones;
  logic         seen;
  logic         far;

  // Hamming distance to the last accepted word
  always_comb begin
    diff = gray_in ^ prev_gray;
    ones = '0;
    for (int i = 0; i < N; i++) begin
      ones = ones + 32'(diff[i]);
    end
    far = (ones >= 32'd2);
  end

  // Remember each accepted word; the first one is never flagged
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_gray <= '0;
      seen      <= 1'b0;
      err       <= 1'b0;
    end else if (accept) begin
      prev_gray <= gray_in;
      seen      <= 1'b1;
      err       <= seen && far;
    end
  end

endmodule

// File: rtl/gray_to_binary_seq.sv
// Serial Gray-to-binary decoder, one bit per clock, MSB first.
// Optional step checking is enabled by GRAY_STEP_CHECK_EN.
module gray_to_binary_seq
  import gray_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] gray_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] bin_out,
  output logic         busy,
  output logic         step_err
);

  localparam int IW = idx_w(N);

  state_t       state;
  state_t       state_n;
  logic [N-1:0] g_q;
  logic [N-1:0] bin_q;
  logic [N-1:0] bin_r;
  logic [N-1:0] bin_n;
  logic [IW-1:0] idx;
  logic         prev;
  logic         bit_n;
  logic         accept;

  assign in_ready = !rst &&
    ((state == IDLE) ||
     ((state == DONE) && out_ready));
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == DONE);
  assign busy      = (state == BUSY);
  assign bin_out   = bin_r;

  // Next state: decode N bits, then hold the result
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (accept) state_n = BUSY;
      BUSY: if (idx == '0) state_n = DONE;
      DONE: begin
        if (out_ready) begin
          state_n = accept ? BUSY : IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Current decoded bit and the partial word it produces
  always_comb begin
    bit_n      = prev ^ g_q[idx];
    bin_n      = bin_q;
    bin_n[idx] = bit_n;
  end

  // Capture on accept, shift one bit per BUSY cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      g_q   <= '0;
      bin_q <= '0;
      bin_r <= '0;
      idx   <= '0;
      prev  <= 1'b0;
    end else if (accept) begin
      g_q  <= gray_in;
      idx  <= IW'(N - 1);
      prev <= 1'b0;
    end else if (state == BUSY) begin
      bin_q <= bin_n;
      prev  <= bit_n;
      if (idx == '0) bin_r <= bin_n;
      else           idx   <= idx - 1'b1;
    end
  end

`ifdef GRAY_STEP_CHECK_EN
  logic err;

  gray_step_checker #(.N(N)) u_chk (
    .clk     (clk),
    .rst     (rst),
    .accept  (accept),
    .gray_in (gray_in),
    .err     (err)
  );

  assign step_err = err && out_valid;
`else
  assign step_err = 1'b0;
`endif

endmodule

// File: tb/tb_gray_to_binary_seq.sv
// Self-checking bench for gray_to_binary_seq (N=4).
// Transaction-level model plus directed and random stimulus.
module tb_gray_to_binary_seq;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic [N-1:0] gray_in = '0;
  logic         in_ready;
  logic         out_valid;
  logic [N-1:0] bin_out;
  logic         busy;
  logic         step_err;

  int checks = 0;
  int failures = 0;

  gray_to_binary_seq #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .gray_in   (gray_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .bin_out   (bin_out),
    .busy      (busy),
    .step_err  (step_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] g2b(input logic [N-1:0] g);
    logic [N-1:0] b;
    b = g;
    for (int s = 1; s < N; s++) b = b ^ (g >> s);
    return b;
  endfunction

  // model: a word is in flight for N cycles, then held until taken
  bit           m_busy = 0;
  bit           m_valid = 0;
  bit           m_err = 0;
  bit           m_pend_err = 0;
  bit           m_first = 1;
  bit           m_acc = 0;
  bit           started = 0;
  int           m_cnt = 0;
  logic [N-1:0] m_bin = '0;
  logic [N-1:0] m_pend = '0;
  logic [N-1:0] m_prevg = '0;

  function automatic bit m_ready();
    return !rst && ((!m_busy && !m_valid) ||
                    (m_valid && out_ready));
  endfunction

  function automatic bit exp_err();
`ifdef GRAY_STEP_CHECK_EN
    return m_err;
`else
    return 1'b0;
`endif
  endfunction

  always @(posedge clk) begin : model
    bit acc;
    acc = in_valid && m_ready();
    started = 1;
    m_acc = 0;
    if (rst) begin
      m_busy = 0; m_valid = 0; m_cnt = 0;
      m_bin = '0; m_err = 0; m_first = 1;
    end else begin
      if (m_busy) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_busy = 0; m_valid = 1;
          m_bin = m_pend; m_err = m_pend_err;
        end
      end else if (m_valid && out_ready) begin
        m_valid = 0;
      end
      if (acc) begin
        m_acc = 1;
        m_busy = 1;
        m_cnt = N;
        m_pend = g2b(gray_in);
        m_pend_err = !m_first &&
          ($countones(gray_in ^ m_prevg) >= 2);
        m_first = 0;
        m_prevg = gray_in;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("in_ready", 32'(in_ready), 32'(m_ready()));
      chk("busy", 32'(busy), 32'(m_busy));
      chk("out_valid", 32'(out_valid), 32'(m_valid));
      if (m_valid) begin
        chk("bin_out", 32'(bin_out), 32'(m_bin));
        chk("step_err", 32'(step_err), 32'(exp_err()));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input  logic [N-1:0] g,
                      output logic [N-1:0] res,
                      output logic         err,
                      output int           lat);
    bit ok;
    ok = 0;
    lat = 0;
    in_valid = 1'b1;
    gray_in = g;
    for (int i = 0; i < 50 && !ok; i++) begin
      tick();
      ok = m_acc;
    end
    in_valid = 1'b0;
    if (!ok) chk("accept_timeout", 0, 1);
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      if (out_valid) begin
        ok = 1;
        break;
      end
      if (busy) lat++;
      gray_in = N'($urandom);
      tick();
    end
    if (!ok) chk("done_timeout", 0, 1);
    res = bin_out;
    err = step_err;
  endtask

  logic [N-1:0] sweep [16] = '{
    4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
    4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8
  };

  logic [N-1:0] step_g [5] = '{
    4'b0011, 4'b0001, 4'b0010, 4'b0011, 4'b0011
  };

  initial begin
    logic [N-1:0] r;
    logic [N-1:0] snap;
    logic         e;
    logic         snap_e;
    int           lat;
    int           last;
    int           idle;
    int           vcnt;
    bit           pb;
    bit           ok;

    chk("model_1000", 32'(g2b(4'b1000)), 32'h0000000F);
    chk("model_0101", 32'(g2b(4'b0101)), 32'h00000006);
    chk("model_0011", 32'(g2b(4'b0011)), 32'h00000002);

    rst = 1'b1;
    tick();
    tick();
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_bin_out", 32'(bin_out), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_step_err", 32'(step_err), 0);
    chk("rst_in_ready", 32'(in_ready), 0);
    rst = 1'b0;
    tick();

    out_ready = 1'b1;
    send(4'b1000, r, e, lat);
    chk("t1_bin", 32'(r), 32'hF);
    chk("t1_latency", lat, N);

    foreach (sweep[i]) begin
      send(sweep[i], r, e, lat);
      chk("t2_sweep", 32'(r), i);
    end
    send(4'b0101, r, e, lat);
    chk("t2_0101", 32'(r), 32'h6);

    tick();
    out_ready = 1'b0;
    send(4'b1100, r, e, lat);
    chk("t3_toggle", 32'(r), 32'h8);
    snap = bin_out;
    snap_e = step_err;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t3_hold_bin", 32'(bin_out), 32'(snap));
      chk("t3_hold_err", 32'(step_err), 32'(snap_e));
      chk("t3_hold_valid", 32'(out_valid), 1);
      chk("t3_hold_ready", 32'(in_ready), 0);
    end
    out_ready = 1'b1;
    tick();
    tick();

    in_valid = 1'b1;
    last = -1;
    idle = 0;
    pb = 0;
    for (int c = 0; c < 30; c++) begin
      gray_in = N'($urandom);
      tick();
      if (busy && !pb) begin
        if (last >= 0) chk("t4_gap", c - last, N + 1);
        last = c;
      end
      if (last >= 0 && !busy && !out_valid) idle++;
      pb = busy;
    end
    in_valid = 1'b0;
    chk("t4_idle", idle, 0);
    for (int i = 0; i < 8; i++) tick();

    in_valid = 1'b1;
    gray_in = 4'b1111;
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      tick();
      ok = m_acc;
    end
    in_valid = 1'b0;
    chk("t5_accept", 32'(ok), 1);
    vcnt = 0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid) vcnt++;
      tick();
    end
    chk("t5_no_valid", vcnt, 0);

    foreach (step_g[i]) begin
      send(step_g[i], r, e, lat);
      chk("t6_bin", 32'(r), 32'(g2b(step_g[i])));
`ifdef GRAY_STEP_CHECK_EN
      chk("t6_step_err", 32'(e), (i == 2) ? 1 : 0);
`else
      chk("t6_step_err", 32'(e), 0);
`endif
    end
    chk("t5_next_word", 32'(g2b(step_g[0])), 32'h2);

    for (int c = 0; c < 600; c++) begin
      in_valid = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      gray_in = N'($urandom);
      rst = ($urandom_range(0, 79) == 0);
      tick();
    end
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) tick();

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
